// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    dmem_req;
    logic                    dmem_we;
    logic [DATA_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic [DATA_WIDTH/8-1:0] dmem_be;
    logic                    dmem_gnt;
    logic                    dmem_rvalid;
    logic [DATA_WIDTH-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores over the dmem req/gnt/rvalid bus, extends load data,
// stalls upstream while an access is outstanding and registers the MEM/WB outputs.
module mem_access_stage #(
    parameter int DATA_WIDTH          = 32,
    parameter int INST_ADDR_WIDTH     = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_EX_MEM_o,
    input  logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o,
    input  logic [DATA_WIDTH-1:0]          write_data_EX_MEM_o,
    input  logic [2:0]                     funct3_EX_MEM_o,
    input  logic                           mem_write_EX_MEM_o,
    input  logic [1:0]                     result_sel_EX_MEM_o,
    input  logic                           reg_write_EX_MEM_o,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
    input  logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_EX_MEM_o,
    mem_access_stage_if.master             dmem,
    output logic                           stall_MEM,
    output logic                           mem_fault_MEM,
    output logic                           reg_write_MEM_WB_o,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM_WB_o,
    output logic [1:0]                     result_sel_MEM_WB_o,
    output logic [DATA_WIDTH-1:0]          alu_res_MEM_WB_o,
    output logic [DATA_WIDTH-1:0]          read_data_MEM_WB_o,
    output logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_MEM_WB_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state_q, state_d;

    logic                    is_store, is_load, mem_op;
    logic                    f3_legal, misaligned, fault;
    logic                    req, retire_load;
    logic [1:0]              lane;
    logic [DATA_WIDTH/8-1:0] be_lanes;
    logic [DATA_WIDTH-1:0]   wdata_lanes;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [DATA_WIDTH-1:0]   load_ext;

    assign lane     = alu_res_EX_MEM_o[1:0];
    assign is_store = mem_write_EX_MEM_o;
    assign is_load  = !mem_write_EX_MEM_o && (result_sel_EX_MEM_o == 2'b01);
    assign mem_op   = valid_EX_MEM_o && (is_store || is_load);

    always_comb begin
        f3_legal = 1'b0;
        case (funct3_EX_MEM_o)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase
    end

    assign misaligned = ((funct3_EX_MEM_o[1:0] == 2'b01) && lane[0]) ||
                        ((funct3_EX_MEM_o[1:0] == 2'b10) && (lane != 2'b00));

    // Legality is only judged on entry; once issued, the held EX/MEM inputs are trusted.
    assign fault = rst_n && (state_q == IDLE) && mem_op && (!f3_legal || misaligned);

    always_comb begin
        be_lanes    = '1;
        wdata_lanes = write_data_EX_MEM_o;
        case (funct3_EX_MEM_o[1:0])
            2'b00: begin
                be_lanes    = 4'b0001 << lane;
                wdata_lanes = {(DATA_WIDTH/8){write_data_EX_MEM_o[7:0]}};
            end
            2'b01: begin
                be_lanes    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {(DATA_WIDTH/16){write_data_EX_MEM_o[15:0]}};
            end
            default: begin
                be_lanes    = '1;
                wdata_lanes = write_data_EX_MEM_o;
            end
        endcase
    end

    assign byte_v = dmem.dmem_rdata[{lane, 3'b000} +: 8];
    assign half_v = dmem.dmem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = dmem.dmem_rdata;
        case (funct3_EX_MEM_o)
            3'b000:  load_ext = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req         = 1'b0;
        stall_MEM   = 1'b0;
        retire_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && !fault) begin
                    req = 1'b1;
                    if (dmem.dmem_gnt) begin
                        if (is_load) begin
                            state_d   = RESP;
                            stall_MEM = 1'b1;
                        end
                    end else begin
                        state_d   = REQ;
                        stall_MEM = 1'b1;
                    end
                end
            end
            REQ: begin
                req       = 1'b1;
                stall_MEM = 1'b1;
                if (dmem.dmem_gnt) begin
                    if (is_load) begin
                        state_d = RESP;
                    end else begin
                        state_d   = IDLE;
                        stall_MEM = 1'b0;
                    end
                end
            end
            RESP: begin
                stall_MEM = 1'b1;
                if (dmem.dmem_rvalid) begin
                    stall_MEM   = 1'b0;
                    retire_load = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Request and stall must fall while reset is held, even with a mem op still presented.
        if (!rst_n) begin
            req         = 1'b0;
            stall_MEM   = 1'b0;
            retire_load = 1'b0;
        end
    end

    assign mem_fault_MEM   = fault;
    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req && is_store;
    assign dmem.dmem_addr  = req ? {alu_res_EX_MEM_o[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem.dmem_wdata = (req && is_store) ? wdata_lanes : '0;
    assign dmem.dmem_be    = req ? be_lanes : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_MEM_WB_o  <= 1'b0;
            rd_MEM_WB_o         <= '0;
            result_sel_MEM_WB_o <= '0;
            alu_res_MEM_WB_o    <= '0;
            read_data_MEM_WB_o  <= '0;
            PC_plus_4_MEM_WB_o  <= '0;
        end else if (stall_MEM) begin
            reg_write_MEM_WB_o <= 1'b0;
        end else begin
            reg_write_MEM_WB_o  <= valid_EX_MEM_o && reg_write_EX_MEM_o && !fault;
            rd_MEM_WB_o         <= rd_EX_MEM_o;
            result_sel_MEM_WB_o <= result_sel_EX_MEM_o;
            alu_res_MEM_WB_o    <= alu_res_EX_MEM_o;
            PC_plus_4_MEM_WB_o  <= PC_plus_4_EX_MEM_o;
            if (retire_load) read_data_MEM_WB_o <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus queues expected bus accesses and WB retirements,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, mem_write, reg_write;
    logic [31:0] alu_res, wdata, pc4;
    logic [2:0]  funct3;
    logic [1:0]  result_sel;
    logic [4:0]  rd;
    logic        stall, fault;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;
    logic [31:0] wb_alu, wb_rdata, wb_pc;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_lanes;
        string       name;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [1:0]  sel;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        chk_rdata;
        string       name;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_WIDTH(32)) dmem ();

    mem_access_stage #(
        .DATA_WIDTH(32),
        .INST_ADDR_WIDTH(32),
        .REGISTER_ADDR_WIDTH(5)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .valid_EX_MEM_o      (valid),
        .alu_res_EX_MEM_o    (alu_res),
        .write_data_EX_MEM_o (wdata),
        .funct3_EX_MEM_o     (funct3),
        .mem_write_EX_MEM_o  (mem_write),
        .result_sel_EX_MEM_o (result_sel),
        .reg_write_EX_MEM_o  (reg_write),
        .rd_EX_MEM_o         (rd),
        .PC_plus_4_EX_MEM_o  (pc4),
        .dmem                (dmem),
        .stall_MEM           (stall),
        .mem_fault_MEM       (fault),
        .reg_write_MEM_WB_o  (wb_rw),
        .rd_MEM_WB_o         (wb_rd),
        .result_sel_MEM_WB_o (wb_sel),
        .alu_res_MEM_WB_o    (wb_alu),
        .read_data_MEM_WB_o  (wb_rdata),
        .PC_plus_4_MEM_WB_o  (wb_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: bus accesses complete on req&gnt, WB retirements show as reg_write_MEM_WB_o=1.
    always @(negedge clk) begin
        if (rst_n && dmem.dmem_req && dmem.dmem_gnt) begin
            if (bus_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_bus: got addr %h expected no access", dmem.dmem_addr);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                chk({e.name, "_we"},   {31'd0, dmem.dmem_we}, {31'd0, e.we});
                chk({e.name, "_addr"}, dmem.dmem_addr, e.addr);
                if (e.chk_lanes) begin
                    chk({e.name, "_be"},    {28'd0, dmem.dmem_be}, {28'd0, e.be});
                    chk({e.name, "_wdata"}, dmem.dmem_wdata, e.wdata);
                end
            end
        end
        if (wb_rw === 1'b1) begin
            if (wb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_wb: got rd %0d expected no retirement", wb_rd);
            end else begin
                wb_t w;
                w = wb_q.pop_front();
                chk({w.name, "_rd"},  {27'd0, wb_rd}, {27'd0, w.rd});
                chk({w.name, "_alu"}, wb_alu, w.alu);
                chk({w.name, "_sel"}, {30'd0, wb_sel}, {30'd0, w.sel});
                chk({w.name, "_pc"},  wb_pc, w.pc);
                if (w.chk_rdata) chk({w.name, "_rdata"}, wb_rdata, w.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic we, input logic [1:0] sel, input logic rw,
                          input logic [4:0] r, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] pc);
        valid = v; mem_write = we; result_sel = sel; reg_write = rw;
        rd = r; funct3 = f3; alu_res = a; wdata = d; pc4 = pc;
    endtask

    task automatic idle();
        valid = 1'b0; mem_write = 1'b0; result_sel = 2'b00; reg_write = 1'b0;
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
        step();
    endtask

    // Drives gnt in cycle gc and rvalid (with rd_word) in cycle rc (rc<0: none), counts stall cycles.
    task automatic run_mem(input int gc, input int rc, input logic [31:0] rd_word, output int stalls);
        logic done;
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            dmem.dmem_gnt    = (c == gc);
            dmem.dmem_rvalid = (c == rc);
            dmem.dmem_rdata  = (c == rc) ? rd_word : 32'h0;
            #3;
            if (stall) stalls++;
            done = !stall;
            step();
            if (done) break;
        end
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
    endtask

    initial begin
        int stalls;
        rst_n = 1'b0;
        set_op(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0);
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
        step(); step();
        chk("rst_req", {31'd0, dmem.dmem_req}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_wb_rw", {31'd0, wb_rw}, 0);
        chk("rst_wb_alu", wb_alu, 0);
        chk("rst_wb_rdata", wb_rdata, 0);
        rst_n = 1'b1;
        step();

        // ADD x5: retires next edge without stalling
        set_op(1, 0, 2'b00, 1, 5, 3'b000, 32'h1234, 0, 32'h1004);
        wb_q.push_back('{5'd5, 32'h1234, 2'b00, 32'h0, 32'h1004, 1'b0, "add"});
        #3 chk("add_stall", {31'd0, stall}, 0);
        step();
        idle();

        // SB 0x103 granted same cycle
        set_op(1, 1, 2'b00, 0, 0, 3'b000, 32'h103, 32'hAB, 32'h1008);
        bus_q.push_back('{1'b1, 32'h100, 4'b1000, 32'hABABABAB, 1'b1, "sb"});
        run_mem(0, -1, 0, stalls);
        chk("sb_stalls", stalls, 0);
        idle();

        // SH 0x102 granted after one wait
        set_op(1, 1, 2'b00, 0, 0, 3'b001, 32'h102, 32'h1234ABCD, 32'h100C);
        bus_q.push_back('{1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 1'b1, "sh"});
        run_mem(1, -1, 0, stalls);
        chk("sh_stalls", stalls, 1);
        idle();

        // LB 0x102: gnt two cycles late, rvalid four cycles after gnt
        set_op(1, 0, 2'b01, 1, 7, 3'b000, 32'h102, 0, 32'h2008);
        bus_q.push_back('{1'b0, 32'h100, 4'b0, 32'h0, 1'b0, "lb"});
        wb_q.push_back('{5'd7, 32'h102, 2'b01, 32'hFFFFFF80, 32'h2008, 1'b1, "lb"});
        run_mem(2, 6, 32'h00800000, stalls);
        chk("lb_stalls", stalls, 6);
        idle();

        // LBU, same timing
        set_op(1, 0, 2'b01, 1, 8, 3'b100, 32'h102, 0, 32'h200C);
        bus_q.push_back('{1'b0, 32'h100, 4'b0, 32'h0, 1'b0, "lbu"});
        wb_q.push_back('{5'd8, 32'h102, 2'b01, 32'h00000080, 32'h200C, 1'b1, "lbu"});
        run_mem(2, 6, 32'h00800000, stalls);
        chk("lbu_stalls", stalls, 6);
        idle();

        // LW 0x106 misaligned: fault, no request, bubble
        set_op(1, 0, 2'b01, 1, 10, 3'b010, 32'h106, 0, 32'h2010);
        dmem.dmem_gnt = 1'b1;
        #3;
        chk("lw_fault", {31'd0, fault}, 1);
        chk("lw_req", {31'd0, dmem.dmem_req}, 0);
        chk("lw_stall", {31'd0, stall}, 0);
        step();
        dmem.dmem_gnt = 1'b0;
        valid = 1'b0;
        #3;
        chk("lw_bubble", {31'd0, wb_rw}, 0);
        chk("lw_fault_pulse", {31'd0, fault}, 0);
        step();

        // LH parked in RESP, then reset
        set_op(1, 0, 2'b01, 1, 9, 3'b001, 32'h102, 0, 32'h3000);
        bus_q.push_back('{1'b0, 32'h100, 4'b0, 32'h0, 1'b0, "lh"});
        dmem.dmem_gnt = 1'b1;
        #3 chk("lh_issue_stall", {31'd0, stall}, 1);
        step();
        dmem.dmem_gnt = 1'b0;
        #3;
        chk("lh_resp_stall", {31'd0, stall}, 1);
        chk("lh_resp_req", {31'd0, dmem.dmem_req}, 0);
        step();
        rst_n = 1'b0;
        #3;
        chk("mid_rst_req", {31'd0, dmem.dmem_req}, 0);
        chk("mid_rst_stall", {31'd0, stall}, 0);
        chk("mid_rst_wb_alu", wb_alu, 0);
        chk("mid_rst_wb_pc", wb_pc, 0);
        step();
        rst_n = 1'b1;
        valid = 1'b0;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'hFFFFFFFF;
        #3 chk("late_rvalid_stall", {31'd0, stall}, 0);
        step();
        dmem.dmem_rvalid = 1'b0;
        #3;
        chk("late_rvalid_wb_rw", {31'd0, wb_rw}, 0);
        chk("late_rvalid_rdata", wb_rdata, 0);
        step();

        // LHU after reset behaves normally
        set_op(1, 0, 2'b01, 1, 11, 3'b101, 32'h102, 0, 32'h3010);
        bus_q.push_back('{1'b0, 32'h100, 4'b0, 32'h0, 1'b0, "lhu"});
        wb_q.push_back('{5'd11, 32'h102, 2'b01, 32'h00008001, 32'h3010, 1'b1, "lhu"});
        run_mem(0, 1, 32'h80010000, stalls);
        chk("lhu_stalls", stalls, 1);
        idle();

        // ADD then SW held in REQ for four cycles
        set_op(1, 0, 2'b00, 1, 3, 3'b000, 32'h55, 0, 32'h4000);
        wb_q.push_back('{5'd3, 32'h55, 2'b00, 32'h0, 32'h4000, 1'b0, "add2"});
        step();
        set_op(1, 1, 2'b00, 0, 0, 3'b010, 32'h200, 32'hDEADBEEF, 32'h4004);
        bus_q.push_back('{1'b1, 32'h200, 4'b1111, 32'hDEADBEEF, 1'b1, "sw"});
        for (int c = 0; c < 4; c++) begin
            dmem.dmem_gnt = 1'b0;
            #3;
            chk("sw_hold_addr", dmem.dmem_addr, 32'h200);
            chk("sw_hold_wdata", dmem.dmem_wdata, 32'hDEADBEEF);
            chk("sw_hold_be", {28'd0, dmem.dmem_be}, 32'hF);
            chk("sw_hold_stall", {31'd0, stall}, 1);
            step();
            chk("sw_bubble", {31'd0, wb_rw}, 0);
            chk("sw_wb_alu_hold", wb_alu, 32'h55);
        end
        dmem.dmem_gnt = 1'b1;
        #3 chk("sw_gnt_stall", {31'd0, stall}, 0);
        step();
        idle();
        idle();

        chk("bus_q_drained", bus_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
